alu_iterative: RTL and testbench
================================

ALU_ITERATIVE -- requirements
Module: alu_iterative

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; SHALL be a power of two, at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL be derived, not overridden.
REQ-003 Port clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port start  in  1  request; SHALL be accepted only when ready=1.
REQ-006 Port A  in  WIDTH  operand A.
REQ-007 Port B  in  WIDTH  operand B; B[SHW-1:0] SHALL be the shift amount.
REQ-008 Port FS  in  5  function select: FS[0] invert B, FS[1] invert A, FS[4:2] op.
REQ-009 Port C0  in  1  adder carry-in.
REQ-010 Port ready  out  1  high when a start will be accepted.
REQ-011 Port done  out  1  one-cycle pulse marking a new F/status.
REQ-012 Port F  out  WIDTH  registered result.
REQ-013 Port status  out  4  registered {V,C,N,Z}.

Function
REQ-014 FS[4:2] SHALL encode: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SHL, 101 SHR (logical), 110 MUL (unsigned, low WIDTH bits of product), 111 DIV (unsigned quotient).
REQ-015 FS[1:0] inversion SHALL apply to AND/OR/ADD/XOR only; SHL, SHR, MUL and DIV SHALL use raw A and B.
REQ-016 On acceptance, A, B, FS and C0 SHALL be captured; input changes after acceptance SHALL be ignored.
REQ-017 The FSM SHALL have two states: IDLE (ready=1) and BUSY (ready=0).
REQ-018 AND, OR, ADD, XOR, SHL and SHR SHALL complete without leaving IDLE. With start accepted in cycle 0, F, status and done=1 SHALL be valid in cycle 1.
REQ-019 MUL and DIV SHALL move to BUSY and execute one bit per cycle for WIDTH cycles (1..WIDTH). They SHALL return to IDLE with F, status and done=1 valid in cycle WIDTH+1.
REQ-020 start while BUSY SHALL be ignored, without queuing or error.
REQ-021 start in a done cycle SHALL be accepted, giving back-to-back operation.
REQ-022 F and status SHALL hold until the next completion; done SHALL be high for exactly one cycle per accepted start.
REQ-023 Z SHALL be (F==0) and N SHALL be F[WIDTH-1] for every op.
REQ-024 C SHALL be the adder carry-out for ADD and 0 otherwise.
REQ-025 For ADD, V SHALL be ~(As[MSB]^Bs[MSB]) & (F[MSB]^As[MSB]), where As/Bs are the post-inversion operands.
REQ-026 For MUL, V SHALL be 1 if any upper WIDTH bits of the 2*WIDTH product are nonzero.
REQ-027 For DIV, V SHALL be 1 if B==0; in that case F SHALL be all ones.
REQ-028 For AND, OR, XOR, SHL and SHR, V SHALL be 0.

Reset
REQ-029 reset SHALL force IDLE, ready=1, done=0, F=0 and status=0 at the next edge.
REQ-030 reset during BUSY SHALL abort the operation, with no done pulse for it.
REQ-031 reset SHALL take priority over a simultaneous start.

Structure
REQ-032 Package alu_pkg SHALL hold the FS[4:2] op-code constants and the status bit indices (V=3, C=2, N=1, Z=0).
REQ-033 The iterative shift-add multiplier and restoring divider SHALL be one sub-module, alu_muldiv_iter, with start/done handshake to the parent.
REQ-034 The single-cycle datapath and the FSM SHALL be inline in alu_iterative.

Verification
REQ-035 WIDTH=64, ADD: A=5, B=3, FS=01000, C0=0 -> cycle 1: F=8, status=0000, done=1.
REQ-036 WIDTH=64, subtract: A=3, B=5, FS=01001, C0=1 -> F=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0, V=0.
REQ-037 WIDTH=64, MUL: A=B=0x1_0000_0000 -> ready=0 in cycles 1..64, then cycle 65: F=0, Z=1, V=1, done=1.
REQ-038 WIDTH=64, DIV: A=100, B=7 -> cycle 65: F=14. Then DIV with B=0 -> F all ones, V=1.
REQ-039 MUL started, start pulsed in cycle 5, reset in cycle 10 -> no done; ready=1, F=0 and status=0 in cycle 11.
REQ-040 WIDTH=8, SHL: A=0x81, B=0x09 -> shift amount 1; F=0x02, N=0, Z=0 in cycle 1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-code and status-bit constants shared by the ALU files
// Purpose: FS[4:2] operation codes and {V,C,N,Z} status bit positions.
// Ports: none (package).
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - bit-serial shift-add multiplier / restoring divider
// Purpose: one operand bit per cycle over WIDTH cycles after start.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   start             : load operands (only honoured while idle)
//   is_div            : 1 = unsigned divide, 0 = unsigned multiply
//   a, b              : multiplicand/dividend, multiplier/divisor
//   done              : high in the cycle the last bit is processed
//   result            : low product half or quotient, valid with done
//   ovf               : MUL: high product half nonzero; DIV: divisor was zero
module alu_muldiv_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy;
  logic             div_q;
  logic             div_zero;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi;    // product high half / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0] d;     // multiplicand / divisor

  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  // The step for the current bit is combinational so the final bit can be
  // handed to the parent in the same cycle it is processed.
  always_comb begin
    nxt_hi    = hi;
    nxt_lo    = lo;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, d};
    if (div_q) begin
      // Restoring step: keep the trial difference only when it did not borrow.
      if (div_diff[WIDTH+1]) begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  assign done   = busy && (cnt == LAST);
  assign result = nxt_lo;
  assign ovf    = div_q ? div_zero : (nxt_hi != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      div_q    <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      d        <= '0;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        div_q    <= is_div;
        div_zero <= (b == '0);
        cnt      <= '0;
        hi       <= '0;
        lo       <= a;
        d        <= b;
      end
    end else begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - ALU with single-cycle logic/add/shift and iterative mul/div
// Purpose: registered ALU result and {V,C,N,Z} status with start/ready/done handshake.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   start        : request, accepted when ready=1
//   A, B         : operands; B[SHW-1:0] is the shift amount
//   FS           : FS[0] invert B, FS[1] invert A, FS[4:2] operation
//   C0           : adder carry-in
//   ready        : a start will be accepted this cycle
//   done         : one-cycle pulse when F/status are updated
//   F, status    : registered result and {V,C,N,Z}
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  alu_state_t state, state_nxt;

  logic             accept;
  logic             is_md;
  logic             md_start;
  logic             md_done;
  logic             md_ovf;
  logic [WIDTH-1:0] md_result;

  logic [2:0]       op;
  logic [WIDTH-1:0] as_op;
  logic [WIDTH-1:0] bs_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_st;
  logic [3:0]       md_st;

  assign op       = FS[4:2];
  assign is_md    = (op == OP_MUL) || (op == OP_DIV);
  assign accept   = start && ready;
  assign md_start = accept && is_md;

  always_comb begin
    ready     = (state == S_IDLE);
    state_nxt = state;
    case (state)
      S_IDLE: if (md_start) state_nxt = S_BUSY;
      S_BUSY: if (md_done)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Single-cycle datapath; inversion only feeds the logic/add ops.
  always_comb begin
    as_op   = FS[1] ? ~A : A;
    bs_op   = FS[0] ? ~B : B;
    sum     = {1'b0, as_op} + {1'b0, bs_op} + {{WIDTH{1'b0}}, C0};
    alu_res = '0;
    alu_st  = '0;
    case (op)
      OP_AND: alu_res = as_op & bs_op;
      OP_OR:  alu_res = as_op | bs_op;
      OP_ADD: alu_res = sum[WIDTH-1:0];
      OP_XOR: alu_res = as_op ^ bs_op;
      OP_SHL: alu_res = A << B[SHW-1:0];
      OP_SHR: alu_res = A >> B[SHW-1:0];
      default: alu_res = '0;
    endcase
    if (op == OP_ADD) begin
      alu_st[ST_C] = sum[WIDTH];
      alu_st[ST_V] = ~(as_op[WIDTH-1] ^ bs_op[WIDTH-1]) & (alu_res[WIDTH-1] ^ as_op[WIDTH-1]);
    end
    alu_st[ST_N] = alu_res[WIDTH-1];
    alu_st[ST_Z] = (alu_res == '0);
  end

  always_comb begin
    md_st       = '0;
    md_st[ST_V] = md_ovf;
    md_st[ST_N] = md_result[WIDTH-1];
    md_st[ST_Z] = (md_result == '0);
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result),
    .ovf    (md_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      F      <= '0;
      status <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !is_md) begin
        F      <= alu_res;
        status <= alu_st;
        done   <= 1'b1;
      end else if (state == S_BUSY && md_done) begin
        F      <= md_result;
        status <= md_st;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed self-checking bench for alu_iterative
module tb_alu_iterative;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start;
  logic [63:0] a, b;
  logic [4:0]  fs;
  logic        c0;
  logic        ready, done;
  logic [63:0] f;
  logic [3:0]  status;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [4:0]  fs8;
  logic        ready8, done8;
  logic [7:0]  f8;
  logic [3:0]  status8;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc;
  int bad;

  always #5 clock = ~clock;

  alu_iterative #(.WIDTH(64)) dut (
    .clock (clock), .reset (reset), .start (start), .A (a), .B (b),
    .FS (fs), .C0 (c0), .ready (ready), .done (done), .F (f), .status (status)
  );

  alu_iterative #(.WIDTH(8)) dut8 (
    .clock (clock), .reset (reset), .start (start8), .A (a8), .B (b8),
    .FS (fs8), .C0 (1'b0), .ready (ready8), .done (done8), .F (f8), .status (status8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a single-cycle op on the 64-bit DUT; returns in cycle 1.
  task automatic op64(input logic [63:0] va, input logic [63:0] vb,
                      input logic [4:0] vfs, input logic vc0);
    a = va; b = vb; fs = vfs; c0 = vc0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done on one of the DUTs; cycle count starts at 1 after the start edge.
  task automatic wait_done(input bit sel8, output int n);
    n = 1;
    while (!(sel8 ? done8 : done) && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    start = 0; a = 0; b = 0; fs = 0; c0 = 0;
    start8 = 0; a8 = 0; b8 = 0; fs8 = 0;
    tick(); tick();
    reset = 1'b0;

    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_f", f, 0);
    check("reset_status", status, 0);

    op64(64'd5, 64'd3, 5'b01000, 0);
    check("add_f", f, 8);
    check("add_status", status, 0);
    check("add_done", done, 1);
    tick();
    check("add_done_pulse", done, 0);
    check("add_f_hold", f, 8);

    op64(64'd3, 64'd5, 5'b01001, 1);
    check("sub_f", f, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_status", status, 4'b0010);

    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 0);
    check("add_ovf_status", status, 4'b1010);
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 0);
    check("add_carry_f", f, 0);
    check("add_carry_status", status, 4'b0101);
    op64(64'hF0, 64'hFF, 5'b00010, 0);
    check("and_inva_f", f, 64'h0F);
    op64(64'h1234, 64'h1234, 5'b01100, 0);
    check("xor_zero_status", status, 4'b0001);
    op64(64'h00F0, 64'h0F00, 5'b00100, 0);
    check("or_f", f, 64'h0FF0);
    op64(64'h8000_0000_0000_0000, 64'd63, 5'b10100, 0);
    check("shr_f", f, 1);
    op64(64'd1, 64'd4, 5'b10011, 0);
    check("shl_noinv_f", f, 64'h10);

    // MUL 2^32*2^32 with inputs changed after accept and a start pulse in cycle 5.
    a = 64'h1_0000_0000; b = 64'h1_0000_0000; fs = 5'b11000; start = 1;
    tick();
    start = 0; a = 64'd3; b = 64'd3;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      if (ready || done) bad++;
      start = (k == 5);
      tick();
    end
    start = 0;
    check("mul_busy_cycles", bad, 0);
    check("mul_done", done, 1);
    check("mul_f", f, 0);
    check("mul_status", status, 4'b1001);
    tick();
    check("mul_done_pulse", done, 0);

    a = 64'd12345; b = 64'd1000; fs = 5'b11000; start = 1;
    tick(); start = 0;
    wait_done(0, cyc);
    check("mul2_latency", cyc, 65);
    check("mul2_f", f, 64'd12345000);

    a = 64'd100; b = 64'd7; fs = 5'b11100; start = 1;
    tick(); start = 0;
    wait_done(0, cyc);
    check("div_latency", cyc, 65);
    check("div_f", f, 14);
    check("div_status", status, 0);
    // back-to-back: start in the done cycle
    a = 64'd100; b = 64'd0; fs = 5'b11100; start = 1;
    tick(); start = 0;
    wait_done(0, cyc);
    check("div0_latency", cyc, 65);
    check("div0_f", f, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_status", status, 4'b1010);
    op64(64'd10, 64'd20, 5'b01000, 0);
    check("b2b_add_done", done, 1);
    check("b2b_add_f", f, 30);

    // reset during BUSY aborts with no done
    a = 64'd77; b = 64'd9; fs = 5'b11000; start = 1;
    tick(); start = 0;
    for (int k = 1; k < 10; k++) begin
      start = (k == 5);
      tick();
    end
    start = 0; reset = 1;
    tick();
    reset = 0;
    check("abort_ready", ready, 1);
    check("abort_f", f, 0);
    check("abort_status", status, 0);
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      if (done) bad++;
      tick();
    end
    check("abort_no_done", bad, 0);

    // WIDTH=8 instance
    a8 = 8'h81; b8 = 8'h09; fs8 = 5'b10000; start8 = 1;
    tick(); start8 = 0;
    check("w8_shl_done", done8, 1);
    check("w8_shl_f", f8, 8'h02);
    check("w8_shl_status", status8, 0);
    a8 = 8'd16; b8 = 8'd16; fs8 = 5'b11000; start8 = 1;
    tick(); start8 = 0;
    wait_done(1, cyc);
    check("w8_mul_latency", cyc, 9);
    check("w8_mul_f", f8, 0);
    check("w8_mul_status", status8, 4'b1001);
    a8 = 8'd200; b8 = 8'd3; fs8 = 5'b11100; start8 = 1;
    tick(); start8 = 0;
    wait_done(1, cyc);
    check("w8_div_latency", cyc, 9);
    check("w8_div_f", f8, 8'd66);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
